alu_bcu_unit: RTL and testbench
===============================

ALU_BCU_UNIT -- requirements
Module: alu_bcu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width for all operands and results.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port src_a  input  WIDTH  ALU operand A; bits [4:0] are also the shift amount.
REQ-005 SHALL have port src_b  input  WIDTH  ALU operand B; this is the value that is shifted.
REQ-006 SHALL have port sig_alu_control  input  5  ALU operation select.
REQ-007 SHALL have port alu_result  output  WIDTH  combinational ALU result.
REQ-008 SHALL have port zero  output  1  combinational; high when alu_result==0.
REQ-009 SHALL have port overflow  output  1  combinational signed overflow for ADD/SUB; 0 for all other ops.
REQ-010 SHALL have port en  input  1  result-register load enable (stall when low).
REQ-011 SHALL have port clr  input  1  result-register synchronous clear (flush).
REQ-012 SHALL have port alu_result_q  output  WIDTH  registered alu_result.
REQ-013 SHALL have port rd1, rd2  input  WIDTH each  branch comparison operands.
REQ-014 SHALL have port sig_bcu_control  input  4  branch condition select.
REQ-015 SHALL have port branch  output  1  combinational branch-taken.
REQ-016 SHALL have port pc_plus_4, sign_imm  input  WIDTH each  branch adder operands.
REQ-017 SHALL have port branch_target  output  WIDTH  combinational pc_plus_4 + (sign_imm<<2), modulo 2^WIDTH.

Function
REQ-018 SHALL decode ALU ops: 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR, 0x05 NOR, 0x06 SLT (signed, result 1/0), 0x07 SLTU (unsigned), 0x08 SLL, 0x09 SRL, 0x0A SRA, 0x0B PASS_B; unused codes output 0.
REQ-019 SHALL compute ADD/SUB modulo 2^WIDTH (wrap, no saturation); overflow=1 when operand signs force a sign-flipped result.
REQ-020 SHALL shift src_b by src_a[4:0]; shift of 0 returns src_b unchanged; SRA replicates src_b[WIDTH-1].
REQ-021 SHALL decode BCU ops: 0x0 NONE (0), 0x1 BEQ rd1==rd2, 0x2 BNE rd1!=rd2, 0x3 BLEZ rd1<=0, 0x4 BGTZ rd1>0, 0x5 BLTZ rd1<0, 0x6 BGEZ rd1>=0, 0x7 ALWAYS (1); signed compares against zero; other codes 0.
REQ-022 SHALL keep alu_result, zero, overflow, branch, branch_target purely combinational (zero latency).
REQ-023 SHALL update alu_result_q on rising clk: priority rst > clr > en; rst or clr load 0; en=1 loads alu_result; en=0 holds (latency 1 cycle).

Reset
REQ-024 SHALL clear alu_result_q to 0 on clk edge with rst=1, including mid-stall; combinational outputs are unaffected by rst.

Configuration
REQ-025 SHALL, with macro ALU_SHIFT_EN defined, implement SLL/SRL/SRA per REQ-020.
REQ-026 SHALL, without ALU_SHIFT_EN, treat codes 0x08-0x0A as unused (alu_result=0, zero=1).

Structure
REQ-027 SHALL place ALU and BCU opcode constants and WIDTH default in shared package alu_bcu_pkg.
REQ-028 SHALL implement the branch adder as one sub-module, branch_adder (WIDTH-bit add, no carry out).

Verification
REQ-029 SHALL test ADD 0x7FFFFFFF+0x00000001 -> alu_result 0x80000000, overflow 1; SUB 5-5 -> 0, zero 1.
REQ-030 SHALL test SLT src_a=0xFFFFFFFF, src_b=1 -> 1; SLTU same operands -> 0.
REQ-031 SHALL test SRA src_b=0x80000000, src_a=4 -> 0xF8000000; SRL same -> 0x08000000 (ALU_SHIFT_EN defined).
REQ-032 SHALL test BEQ rd1=rd2=0x1234 -> branch 1; BGTZ rd1=0 -> 0; BLTZ rd1=0x80000000 -> 1; code 0xF -> 0.
REQ-033 SHALL test branch_target pc_plus_4=0x00400004, sign_imm=0xFFFFFFFF -> 0x00400000.
REQ-034 SHALL test register: load 0xAA, en=0 holds 0xAA, clr=1 with en=1 -> 0, rst=1 with clr=0,en=1 -> 0.

Source files
------------

// File: rtl/alu_bcu_pkg.sv
// Shared opcode encodings and default datapath width for the ALU/BCU slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_bcu_pkg;

    localparam int DefaultWidth = 32;

    // ALU operation select codes (5-bit)
    localparam logic [4:0] AluAdd   = 5'h00;
    localparam logic [4:0] AluSub   = 5'h01;
    localparam logic [4:0] AluAnd   = 5'h02;
    localparam logic [4:0] AluOr    = 5'h03;
    localparam logic [4:0] AluXor   = 5'h04;
    localparam logic [4:0] AluNor   = 5'h05;
    localparam logic [4:0] AluSlt   = 5'h06;
    localparam logic [4:0] AluSltu  = 5'h07;
    localparam logic [4:0] AluSll   = 5'h08;
    localparam logic [4:0] AluSrl   = 5'h09;
    localparam logic [4:0] AluSra   = 5'h0A;
    localparam logic [4:0] AluPassB = 5'h0B;

    // Branch condition select codes (4-bit)
    localparam logic [3:0] BcuNone   = 4'h0;
    localparam logic [3:0] BcuBeq    = 4'h1;
    localparam logic [3:0] BcuBne    = 4'h2;
    localparam logic [3:0] BcuBlez   = 4'h3;
    localparam logic [3:0] BcuBgtz   = 4'h4;
    localparam logic [3:0] BcuBltz   = 4'h5;
    localparam logic [3:0] BcuBgez   = 4'h6;
    localparam logic [3:0] BcuAlways = 4'h7;

endpackage

// File: rtl/branch_adder.sv
// Branch target adder: pcPlus4 + (signImm << 2), wrapping at WIDTH bits.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module branch_adder
    import alu_bcu_pkg::*;
#(
    parameter int WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] pcPlus4,
    input  logic [WIDTH-1:0] signImm,
    output logic [WIDTH-1:0] target
);

    // Word-aligned offset added to the next PC; carry out is dropped on purpose
    assign target = pcPlus4 + (signImm << 2);

endmodule

// File: rtl/alu_bcu_unit.sv
// ALU + branch condition unit + branch adder, with one registered ALU result.
// Latency: alu_result/zero/overflow/branch/branch_target combinational; alu_result_q 1 cycle.
// Backpressure: en=0 stalls (holds) alu_result_q, clr flushes it; ALU_SHIFT_EN enables SLL/SRL/SRA.
module alu_bcu_unit
    import alu_bcu_pkg::*;
#(
    parameter int WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       sig_alu_control,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             overflow,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] alu_result_q,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [3:0]       sig_bcu_control,
    output logic             branch,
    input  logic [WIDTH-1:0] pc_plus_4,
    input  logic [WIDTH-1:0] sign_imm,
    output logic [WIDTH-1:0] branch_target
);

    localparam int MsbIdx = WIDTH - 1;

    logic [WIDTH-1:0] sumAb;
    logic [WIDTH-1:0] diffAb;
    logic             sltBit;
    logic             sltuBit;
    logic             addOvf;
    logic             subOvf;
    logic             rd1Neg;
    logic             rd1Zero;

    assign sumAb   = src_a + src_b;
    assign diffAb  = src_a - src_b;
    assign sltBit  = $signed(src_a) < $signed(src_b);
    assign sltuBit = src_a < src_b;

    // Signed overflow: same-sign operands (ADD) or opposite-sign operands (SUB)
    // producing a result whose sign differs from src_a.
    assign addOvf = (src_a[MsbIdx] == src_b[MsbIdx]) && (sumAb[MsbIdx]  != src_a[MsbIdx]);
    assign subOvf = (src_a[MsbIdx] != src_b[MsbIdx]) && (diffAb[MsbIdx] != src_a[MsbIdx]);

`ifdef ALU_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = src_a[4:0];
`endif

    // ALU operation decode; unused codes (and shifts when disabled) give 0
    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        case (sig_alu_control)
            AluAdd: begin
                alu_result = sumAb;
                overflow   = addOvf;
            end
            AluSub: begin
                alu_result = diffAb;
                overflow   = subOvf;
            end
            AluAnd:   alu_result = src_a & src_b;
            AluOr:    alu_result = src_a | src_b;
            AluXor:   alu_result = src_a ^ src_b;
            AluNor:   alu_result = ~(src_a | src_b);
            AluSlt:   alu_result = {{(WIDTH-1){1'b0}}, sltBit};
            AluSltu:  alu_result = {{(WIDTH-1){1'b0}}, sltuBit};
`ifdef ALU_SHIFT_EN
            AluSll:   alu_result = src_b << shamt;
            AluSrl:   alu_result = src_b >> shamt;
            AluSra:   alu_result = $unsigned($signed(src_b) >>> shamt);
`endif
            AluPassB: alu_result = src_b;
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    assign rd1Neg  = rd1[MsbIdx];
    assign rd1Zero = (rd1 == '0);

    // Branch condition decode; zero-compares treat rd1 as signed
    always_comb begin
        branch = 1'b0;
        case (sig_bcu_control)
            BcuNone:   branch = 1'b0;
            BcuBeq:    branch = (rd1 == rd2);
            BcuBne:    branch = (rd1 != rd2);
            BcuBlez:   branch = rd1Neg | rd1Zero;
            BcuBgtz:   branch = ~rd1Neg & ~rd1Zero;
            BcuBltz:   branch = rd1Neg;
            BcuBgez:   branch = ~rd1Neg;
            BcuAlways: branch = 1'b1;
            default:   branch = 1'b0;
        endcase
    end

    branch_adder #(
        .WIDTH (WIDTH)
    ) uBranchAdder (
        .pcPlus4 (pc_plus_4),
        .signImm (sign_imm),
        .target  (branch_target)
    );

    // Result register: reset beats flush beats load; stall holds the value
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_q <= '0;
        end else if (clr) begin
            alu_result_q <= '0;
        end else if (en) begin
            alu_result_q <= alu_result;
        end
    end

endmodule

// File: tb/tb_alu_bcu_unit.sv
// Self-checking bench for alu_bcu_unit: arithmetic reference model plus literal vectors.
// Latency: checks combinational outputs same cycle, alu_result_q one cycle after load.
// Backpressure: exercises en stall, clr flush and rst priority on the result register.
module tb_alu_bcu_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  src_a, src_b;
    logic [4:0]    sig_alu_control;
    logic [W-1:0]  alu_result;
    logic          zero, overflow;
    logic          en, clr;
    logic [W-1:0]  alu_result_q;
    logic [W-1:0]  rd1, rd2;
    logic [3:0]    sig_bcu_control;
    logic          branch;
    logic [W-1:0]  pc_plus_4, sign_imm;
    logic [W-1:0]  branch_target;

    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;
    logic [W-1:0] modelQ = '0;

    always #5 clk = ~clk;

    alu_bcu_unit #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .src_a           (src_a),
        .src_b           (src_b),
        .sig_alu_control (sig_alu_control),
        .alu_result      (alu_result),
        .zero            (zero),
        .overflow        (overflow),
        .en              (en),
        .clr             (clr),
        .alu_result_q    (alu_result_q),
        .rd1             (rd1),
        .rd2             (rd2),
        .sig_bcu_control (sig_bcu_control),
        .branch          (branch),
        .pc_plus_4       (pc_plus_4),
        .sign_imm        (sign_imm),
        .branch_target   (branch_target)
    );

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic logic [W-1:0] mAlu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        int     sh;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        sh = int'(a[4:0]);
        case (op)
            5'h00: return W'(ua + ub);
            5'h01: return W'(ua - ub);
            5'h02: return a & b;
            5'h03: return a | b;
            5'h04: return a ^ b;
            5'h05: return ~(a | b);
            5'h06: return (sa < sb) ? W'(1) : W'(0);
            5'h07: return (ua < ub) ? W'(1) : W'(0);
`ifdef ALU_SHIFT_EN
            5'h08: return W'(ub * (64'd1 << sh));
            5'h09: return W'(ub / (64'd1 << sh));
            5'h0A: return W'(sb >>> sh);
`endif
            5'h0B: return b;
            default: return '0;
        endcase
    endfunction

    function automatic logic mOvf(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 5'h00)      r = sa + sb;
        else if (op == 5'h01) r = sa - sb;
        else                  return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic mBr(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        s = $signed(a);
        case (op)
            4'h1: return a == b;
            4'h2: return a != b;
            4'h3: return s <= 0;
            4'h4: return s > 0;
            4'h5: return s < 0;
            4'h6: return s >= 0;
            4'h7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] mTgt(input logic [W-1:0] pc, input logic [W-1:0] imm);
        logic [63:0] t;
        t = {32'b0, pc} + {32'b0, imm} * 64'd4;
        return t[W-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Register model follows the rst > clr > en rule on each rising edge
    always @(posedge clk) begin
        if (rst)      modelQ <= '0;
        else if (clr) modelQ <= '0;
        else if (en)  modelQ <= mAlu(sig_alu_control, src_a, src_b);
    end

    // Compare process: every falling edge once out of reset
    always @(negedge clk) begin
        if (started) begin
            chk("cmp_alu",  alu_result,    mAlu(sig_alu_control, src_a, src_b));
            chk("cmp_zero", zero,          mAlu(sig_alu_control, src_a, src_b) == '0);
            chk("cmp_ovf",  overflow,      mOvf(sig_alu_control, src_a, src_b));
            chk("cmp_br",   branch,        mBr(sig_bcu_control, rd1, rd2));
            chk("cmp_tgt",  branch_target, mTgt(pc_plus_4, sign_imm));
            chk("cmp_q",    alu_result_q,  modelQ);
        end
    end

    // ---------------- directed vectors with literal expectations ----------------
    task automatic aluVec(input string name, input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expR, input logic expZ, input logic expO);
        @(negedge clk);
        #1;
        sig_alu_control = op;
        src_a = a;
        src_b = b;
        #2;
        chk({name, "_res"}, alu_result, expR);
        chk({name, "_zero"}, zero, expZ);
        chk({name, "_ovf"}, overflow, expO);
    endtask

    task automatic bcuVec(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic expB);
        @(negedge clk);
        #1;
        sig_bcu_control = op;
        rd1 = a;
        rd2 = b;
        #2;
        chk(name, branch, expB);
    endtask

    task automatic regStep(input string name, input logic [W-1:0] b, input logic e, input logic c,
                           input logic r, input logic [W-1:0] expQ);
        @(negedge clk);
        #1;
        sig_alu_control = 5'h0B;
        src_b = b;
        en  = e;
        clr = c;
        rst = r;
        @(posedge clk);
        #1;
        chk(name, alu_result_q, expQ);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got 0 want 1");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        src_a = '0; src_b = '0; sig_alu_control = '0;
        rd1 = '0; rd2 = '0; sig_bcu_control = '0;
        pc_plus_4 = '0; sign_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", alu_result_q, 0);
        started = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;

        aluVec("add_ovf",  5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
        aluVec("add_wrap", 5'h00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
        aluVec("sub_zero", 5'h01, 32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0);
        aluVec("sub_ovf",  5'h01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
        aluVec("and",      5'h02, 32'hF0F0FFFF, 32'h0FF0F00F, 32'h00F0F00F, 1'b0, 1'b0);
        aluVec("or",       5'h03, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0, 1'b0);
        aluVec("xor",      5'h04, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0);
        aluVec("nor",      5'h05, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b0);
        aluVec("slt",      5'h06, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
        aluVec("sltu",     5'h07, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
`ifdef ALU_SHIFT_EN
        aluVec("sra",      5'h0A, 32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0);
        aluVec("srl",      5'h09, 32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0);
        aluVec("sll",      5'h08, 32'd31,       32'h00000001, 32'h80000000, 1'b0, 1'b0);
        aluVec("sra_sh0",  5'h0A, 32'd0,        32'h80000000, 32'h80000000, 1'b0, 1'b0);
        aluVec("srl_msk",  5'h09, 32'h00000024, 32'h80000000, 32'h08000000, 1'b0, 1'b0);
`else
        aluVec("sra_off",  5'h0A, 32'd4,        32'h80000000, 32'h00000000, 1'b1, 1'b0);
        aluVec("srl_off",  5'h09, 32'd4,        32'h80000000, 32'h00000000, 1'b1, 1'b0);
        aluVec("sll_off",  5'h08, 32'd1,        32'h00000001, 32'h00000000, 1'b1, 1'b0);
`endif
        aluVec("passb",    5'h0B, 32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0);
        aluVec("unused_c", 5'h0C, 32'h12345678, 32'hCAFEF00D, 32'h00000000, 1'b1, 1'b0);
        aluVec("unused_1f",5'h1F, 32'h12345678, 32'hCAFEF00D, 32'h00000000, 1'b1, 1'b0);

        bcuVec("none",     4'h0, 32'h1234,     32'h1234,     1'b0);
        bcuVec("beq",      4'h1, 32'h1234,     32'h1234,     1'b1);
        bcuVec("beq_ne",   4'h1, 32'h1234,     32'h1235,     1'b0);
        bcuVec("bne",      4'h2, 32'h1234,     32'h1235,     1'b1);
        bcuVec("blez_0",   4'h3, 32'h0,        32'h0,        1'b1);
        bcuVec("blez_pos", 4'h3, 32'h1,        32'h0,        1'b0);
        bcuVec("bgtz_0",   4'h4, 32'h0,        32'h0,        1'b0);
        bcuVec("bgtz_max", 4'h4, 32'h7FFFFFFF, 32'h0,        1'b1);
        bcuVec("bltz_min", 4'h5, 32'h80000000, 32'h0,        1'b1);
        bcuVec("bgez_neg", 4'h6, 32'hFFFFFFFF, 32'h0,        1'b0);
        bcuVec("bgez_0",   4'h6, 32'h0,        32'h0,        1'b1);
        bcuVec("always",   4'h7, 32'h0,        32'h5,        1'b1);
        bcuVec("code_f",   4'hF, 32'h1234,     32'h1234,     1'b0);

        @(negedge clk);
        #1;
        pc_plus_4 = 32'h00400004;
        sign_imm  = 32'hFFFFFFFF;
        #2;
        chk("tgt_back", branch_target, 32'h00400000);
        @(negedge clk);
        #1;
        pc_plus_4 = 32'hFFFFFFFC;
        sign_imm  = 32'h00000002;
        #2;
        chk("tgt_wrap", branch_target, 32'h00000004);

        regStep("reg_load",      32'hAA, 1'b1, 1'b0, 1'b0, 32'hAA);
        regStep("reg_hold",      32'h55, 1'b0, 1'b0, 1'b0, 32'hAA);
        regStep("reg_clr",       32'h55, 1'b1, 1'b1, 1'b0, 32'h00);
        regStep("reg_reload",    32'hAA, 1'b1, 1'b0, 1'b0, 32'hAA);
        regStep("reg_stall_rst", 32'h55, 1'b0, 1'b0, 1'b1, 32'h00);
        regStep("reg_reload2",   32'hAA, 1'b1, 1'b0, 1'b0, 32'hAA);
        regStep("reg_rst",       32'h55, 1'b1, 1'b0, 1'b1, 32'h00);
        regStep("reg_after",     32'h77, 1'b1, 1'b0, 1'b0, 32'h77);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
